program_loader: RTL

Boot-time writer for the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles 19-bit instruction words, and writes them sequentially into the instruction-memory write port (WR_EN / ADDRESS / WR_DATA). It holds the CPU enable low until a complete, validated image is in memory. It is the write-side counterpart of the CPU's instruction fetch path.

---
 rtl/program_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader -- boot-time writer for the CPU instruction memory.
//
// Takes a byte stream (valid/ready), assembles WORD_SIZE-bit words from
// three little-endian bytes and writes them to consecutive addresses from
// BASE_ADDR. CPU_EN is held low until the whole image is in memory.
// Stream: LEN_LO LEN_HI { B0 B1 B2 } x N [CHK]
//
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing CHK
// byte; the XOR of every accepted byte (length bytes and CHK included)
// must then be zero for the image to be accepted.
//
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   START             one-cycle pulse; starts a load from IDLE/DONE/ERR
//   IN_DATA/IN_VALID  stream byte and its valid
//   IN_READY          loader can take a byte (registered, state-only)
//   WR_EN/ADDRESS/WR_DATA  instruction-memory write port
//   CPU_EN, DONE      image loaded and validated
//   ERROR             load aborted (bad length, bad B2, bad checksum)
module program_loader #(
  parameter int WORD_SIZE  = 19,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [WORD_SIZE-1:0]  WR_DATA,
  output logic                  CPU_EN,
  output logic                  DONE,
  output logic                  ERROR
);

  // Largest image that fits between BASE_ADDR and the top of memory.
  localparam int unsigned MAX_N = (32'd1 << ADDR_WIDTH) - 32'(BASE_ADDR);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d, b0_q, b0_d, b1_q, b1_d;
  logic [ADDR_WIDTH:0]   n_q, n_d, idx_q, idx_d;
  logic                  ready_q, ready_d, wr_en_q, wr_en_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic                xfer;
  logic [15:0]         n_full;
  logic                len_bad, b2_bad;
  logic [23:0]         word;
  logic [ADDR_WIDTH:0] idx_inc;

  assign xfer    = IN_VALID && ready_q;
  assign n_full  = {IN_DATA, len_lo_q};
  assign len_bad = (IN_DATA[7:4] != 4'd0) || (32'(n_full) > MAX_N);
  assign word    = {IN_DATA, b1_q, b0_q};
  // Bits of B2 above the instruction width must be zero.
  assign b2_bad  = |IN_DATA[7:WORD_SIZE-16];
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    n_d      = n_q;
    idx_d    = idx_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d    = xfer ? (xor_q ^ IN_DATA) : xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (START) begin
        state_d = S_LEN_LO;
        idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = 8'd0;
`endif
      end
      S_LEN_LO: if (xfer) begin
        len_lo_d = IN_DATA;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) begin
        n_d = n_full[ADDR_WIDTH:0];
        if (len_bad)           state_d = S_ERR;
        else if (n_full == '0) state_d = S_FINISH;
        else                   state_d = S_B0;
      end
      S_B0: if (xfer) begin b0_d = IN_DATA; state_d = S_B1; end
      S_B1: if (xfer) begin b1_d = IN_DATA; state_d = S_B2; end
      S_B2: if (xfer) begin
        if (b2_bad) state_d = S_ERR;
        else begin
          // Write port is loaded here so it is valid throughout WRITE.
          state_d = S_WRITE;
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(BASE_ADDR) + idx_q[ADDR_WIDTH-1:0];
          data_d  = word[WORD_SIZE-1:0];
        end
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? S_FINISH : S_B0;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = ((xor_q ^ IN_DATA) == 8'd0) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2)
`ifdef LOADER_CHECKSUM_EN
              || (state_d == S_CHK)
`endif
              ;
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign IN_READY = ready_q;
  assign WR_EN    = wr_en_q;
  assign ADDRESS  = addr_q;
  assign WR_DATA  = data_q;
  assign DONE     = done_q;
  assign CPU_EN   = done_q;
  assign ERROR    = err_q;

endmodule
